arbitro_drenaje: RTL and testbench

//  Output-side drain arbiter: pops the 4 destination FIFOs loaded by the routing arbiter.

---
 rtl/arbitro_drenaje_pkg.sv | 15 +
 rtl/arbitro_drenaje_rr_arbiter4.sv | 40 ++++
 rtl/arbitro_drenaje.sv | 136 +++++++++++++
 tb/tb_arbitro_drenaje.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_drenaje_pkg.sv
// Shared definitions for the output-side drain arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arbitro_drenaje_pkg;

    localparam int N_PORTS = 4;
    localparam int PTR_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_STALL  = 2'd2
    } state_t;

endpackage

// File: rtl/arbitro_drenaje_rr_arbiter4.sv
// Round-robin pick among 4 requesters, starting just after rr_ptr.
// Latency: purely combinational.
// Backpressure: none; the caller gates the grant.
//
// Ports:
//   rr_ptr    : last granted port; the search starts at rr_ptr+1
//   req       : request vector (bit i = port i wants service)
//   grant     : one-hot grant, all zero when no request
//   grant_idx : binary index of the granted port (meaningful when grant_vld)
//   grant_vld : at least one request present
module rr_arbiter4
    import arbitro_drenaje_pkg::*;
(
    input  logic [PTR_W-1:0]   rr_ptr,
    input  logic [N_PORTS-1:0] req,
    output logic [N_PORTS-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               grant_vld
);

    logic [PTR_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        cand      = '0;
        // Offsets 1..4; the 2-bit wrap makes offset 4 land on rr_ptr itself,
        // so the last-served port is considered last.
        for (int k = 1; k <= N_PORTS; k++) begin
            cand = rr_ptr + PTR_W'(k);
            if (!grant_vld && req[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        grant[grant_idx] = grant_vld;
    end

endmodule

// File: rtl/arbitro_drenaje.sv
// Drains 4 destination FIFOs round-robin into one downstream write port.
// Latency: pop -> push exactly 2 cycles (FIFO registered read + output register).
// Backpressure: almost_full blocks new pops; up to 2 in-flight words still pushed.
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   empty        : per-FIFO empty flags
//   fifo_data    : per-FIFO read data, port i at [i*DATA_W +: DATA_W], valid 1 cycle after pop
//   almost_full  : downstream FIFO has only 2 free entries left
//   pop          : one-hot read strobe (combinational from registered state)
//   push/data_out: downstream write strobe and word (registered)
//   idle         : FSM in IDLE (nothing queued, nothing in flight)
//   count        : per-port drained-word counters, port i at [i*CNT_W +: CNT_W], wrapping
module arbitro_drenaje
    import arbitro_drenaje_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int CNT_W  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_PORTS-1:0]          empty,
    input  logic [N_PORTS*DATA_W-1:0]   fifo_data,
    input  logic                        almost_full,
    output logic [N_PORTS-1:0]          pop,
    output logic                        push,
    output logic [DATA_W-1:0]           data_out,
    output logic                        idle,
    output logic [N_PORTS*CNT_W-1:0]    count
);

    state_t                           state_q, state_d;
    logic [PTR_W-1:0]                 rr_ptr_q, rr_ptr_d;
    logic                             v1_q, v1_d;
    logic [PTR_W-1:0]                 sel1_q, sel1_d;
    logic                             v2_q, v2_d;
    logic [DATA_W-1:0]                data_out_q, data_out_d;
    logic [N_PORTS-1:0][CNT_W-1:0]    count_q, count_d;

    logic [N_PORTS-1:0][DATA_W-1:0]   fifo_words;
    logic [N_PORTS-1:0]               grant;
    logic [PTR_W-1:0]                 grant_idx;
    logic                             grant_vld;
    logic                             pop_en;
    logic                             pop_any;
    logic                             all_empty;
    logic                             in_flight;

    assign fifo_words = fifo_data;

    rr_arbiter4 u_rr (
        .rr_ptr    (rr_ptr_q),
        .req       (~empty),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    // No pops while in STALL (even on the cycle almost_full drops) or while
    // reset is held, so a FIFO is never read into a pipeline about to be cleared.
    assign pop_en  = !reset && (state_q != ST_STALL) && !almost_full;
    assign pop_any = pop_en && grant_vld;
    assign pop     = pop_en ? grant : '0;

    assign all_empty = &empty;
    assign in_flight = v1_q || v2_q;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;

        // Stage 1 remembers which FIFO was popped; stage 2 is the push.
        v1_d   = pop_any;
        sel1_d = grant_idx;
        v2_d   = v1_q;
        if (v1_q) begin
            data_out_d = fifo_words[sel1_q];
        end

        if (pop_any) begin
            rr_ptr_d           = grant_idx;
            count_d[grant_idx] = count_q[grant_idx] + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (!all_empty && !almost_full) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (almost_full) begin
                    state_d = ST_STALL;
                end else if (all_empty && !in_flight) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STALL: begin
                // With words still in flight but nothing queued, ACTIVE finishes
                // the drain and then falls back to IDLE.
                if (!almost_full) begin
                    state_d = (all_empty && !in_flight) ? ST_IDLE : ST_ACTIVE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= PTR_W'(N_PORTS - 1);
            v1_q       <= 1'b0;
            sel1_q     <= '0;
            v2_q       <= 1'b0;
            data_out_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            v1_q       <= v1_d;
            sel1_q     <= sel1_d;
            v2_q       <= v2_d;
            data_out_q <= data_out_d;
            count_q    <= count_d;
        end
    end

    assign push     = v2_q;
    assign data_out = data_out_q;
    assign idle     = (state_q == ST_IDLE);
    assign count    = count_q;

endmodule

// File: tb/tb_arbitro_drenaje.sv
// Bench for arbitro_drenaje: four depth-8 registered-read FIFOs in front,
// a word scoreboard behind, and a round-robin reference built from plain queues.
module tb_arbitro_drenaje;

    localparam int DW = 12;
    localparam int CW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      empty;
    logic [4*DW-1:0] fifo_data;
    logic            almost_full;
    logic [3:0]      pop;
    logic            push;
    logic [DW-1:0]   data_out;
    logic            idle;
    logic [4*CW-1:0] count;

    arbitro_drenaje #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .empty       (empty),
        .fifo_data   (fifo_data),
        .almost_full (almost_full),
        .pop         (pop),
        .push        (push),
        .data_out    (data_out),
        .idle        (idle),
        .count       (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [DW-1:0] w;
    } pend_t;

    logic [DW-1:0] fq [4][$];
    logic [DW-1:0] rd_data [4];
    pend_t         pend [$];
    logic [CW-1:0] mcnt [4];
    int            last_port;
    bit            af_prev;
    int            cyc;
    int            n_assert;
    int            n_fail;
    int            fed;

    assign fifo_data = {rd_data[3], rd_data[2], rd_data[1], rd_data[0]};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < 4; i++) empty[i] = (fq[i].size() == 0);
    endtask

    task automatic load(input int p, input int n);
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            if (fq[p].size() < 8) begin
                w      = DW'($urandom);
                w[9:8] = 2'(p);
                fq[p].push_back(w);
            end
        end
        refresh();
    endtask

    // Next port after `last` (cyclically) whose FIFO holds data.
    function automatic logic [3:0] rr_pick(input int last, input logic [3:0] nonempty);
        logic [3:0] one;
        int         p;
        one = 4'b0001;
        for (int k = 1; k <= 4; k++) begin
            p = (last + k) % 4;
            if (nonempty[p]) return one << p;
        end
        return 4'b0000;
    endfunction

    function automatic bit all_drained();
        return (fq[0].size() == 0) && (fq[1].size() == 0) &&
               (fq[2].size() == 0) && (fq[3].size() == 0) && (pend.size() == 0);
    endfunction

    // One clock: sample and check at negedge, then advance the FIFO/scoreboard
    // model just after the posedge.
    task automatic step();
        logic [3:0]    pop_s;
        logic [3:0]    exp_pop;
        bit            rst_s;
        bit            af_s;
        int            p;
        logic [DW-1:0] w;
        @(negedge clk);
        pop_s = pop;
        rst_s = reset;
        af_s  = almost_full;
        exp_pop = (rst_s || af_s) ? 4'b0000 : rr_pick(last_port, ~empty);
        // Right after a backpressure window a single idle cycle is tolerated.
        if (!rst_s && af_prev && !af_s)
            chk("pop_after_release", (pop_s == 4'b0000) || (pop_s == exp_pop), 1);
        else
            chk("pop", pop_s, exp_pop);
        if (pend.size() > 0 && pend[0].due == cyc) begin
            chk("push", push, 1);
            chk("data_out", data_out, pend[0].w);
            void'(pend.pop_front());
        end else begin
            chk("push", push, 0);
        end
        chk("count", count, {mcnt[3], mcnt[2], mcnt[1], mcnt[0]});
        @(posedge clk);
        #1;
        if (rst_s) begin
            pend.delete();
            last_port = 3;
            for (int i = 0; i < 4; i++) mcnt[i] = '0;
            af_prev = 1'b0;
        end else begin
            p = -1;
            for (int i = 0; i < 4; i++) if (pop_s[i] && p < 0) p = i;
            if (p >= 0 && fq[p].size() > 0) begin
                w = fq[p].pop_front();
                rd_data[p] = w;
                pend.push_back('{due: cyc + 2, w: w});
                last_port = p;
                mcnt[p]++;
            end
            af_prev = af_s;
        end
        cyc++;
        refresh();
    endtask

    task automatic drain(input string tag);
        int i;
        almost_full = 1'b0;
        i = 0;
        while (!all_drained() && i < 400) begin
            step();
            i++;
        end
        chk({tag, "_drain_done"}, all_drained(), 1);
        repeat (3) step();
        chk({tag, "_idle"}, idle, 1);
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        cyc         = 0;
        last_port   = 3;
        af_prev     = 1'b0;
        reset       = 1'b1;
        almost_full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_data[i] = '0;
            mcnt[i]    = '0;
        end
        refresh();

        // 1: reset held with non-empty FIFOs
        load(0, 3);
        load(3, 2);
        repeat (2) @(posedge clk);
        #1;
        step();
        step();
        chk("rst_idle", idle, 1);
        chk("rst_push", push, 0);
        chk("rst_count", count, 0);
        reset = 1'b0;
        drain("t1");

        // 2: fairness, 3 words in every FIFO
        reset_pulse();
        for (int p = 0; p < 4; p++) load(p, 3);
        drain("t2");
        chk("t2_count", count, 32'h0303_0303);

        // 3: only FIFO2, back-to-back
        load(2, 5);
        drain("t3");
        chk("t3_count2", count[23:16], 8);

        // 4: backpressure window mid-stream
        load(0, 6);
        load(1, 6);
        repeat (3) step();
        almost_full = 1'b1;
        repeat (4) step();
        almost_full = 1'b0;
        drain("t4");

        // 5: reset right after a pop
        load(3, 4);
        step();
        reset_pulse();
        chk("t5_count", count, 0);
        chk("t5_push", push, 0);
        drain("t5");

        // 6: 257 words through FIFO1 wrap the counter
        reset_pulse();
        fed = 0;
        for (int i = 0; i < 600 && fed < 257; i++) begin
            if (fq[1].size() < 8) begin
                load(1, 1);
                fed++;
            end
            step();
        end
        chk("t6_fed", fed, 257);
        drain("t6");
        chk("t6_count", count, 32'h0000_0100);

        // random traffic with random backpressure
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) != 0) load($urandom_range(0, 3), $urandom_range(1, 3));
            almost_full = ($urandom_range(0, 4) == 0);
            step();
        end
        drain("rnd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
